// File: rtl/bus_rr_scheduler_if.sv
// Bus scheduler interface: device FIFO handshake, shared bus data, status.
// master = scheduler side, slave = device/environment side.
interface bus_rr_scheduler_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;
  logic [drvrs-1:0]         grant;
  logic                     busy;
  logic [15:0]              pkt_cnt;
  logic [15:0]              drop_cnt;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, grant,
    output busy, pkt_cnt, drop_cnt
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, grant,
    input  busy, pkt_cnt, drop_cnt
  );
endinterface

// File: rtl/bus_rr_scheduler.sv
// Round-robin packet bus scheduler: IDLE -> POP -> DELIVER per packet.
// Ports: clk, reset (async active-low), bus (master modport of _if).
module bus_rr_scheduler #(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic           clk,
  input  logic           reset,
  bus_rr_scheduler_if.master bus
);
  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam logic [drvrs-1:0] ONE = drvrs'(1);

  typedef enum logic [1:0] {IDLE, POP, DELIVER} state_t;

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      win_q;
  logic [PW-1:0]      win_d;
  logic               found;
  int                 idx;
  logic [pckg_sz-1:0] pkt_reg;
  logic [7:0]         dest;

  // first pending device searching upward from ptr+1 with wrap
  always_comb begin
    win_d = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < drvrs; k++) begin
      idx = (int'(ptr) + 1 + k) % drvrs;
      if (!found && bus.pndng[idx]) begin
        found = 1'b1;
        win_d = PW'(idx);
      end
    end
  end

  assign dest = pkt_reg[pckg_sz-1 -: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= PW'(drvrs - 1);
      win_q        <= '0;
      pkt_reg      <= '0;
      bus.pop      <= '0;
      bus.push     <= '0;
      bus.D_push   <= '0;
      bus.grant    <= '0;
      bus.busy     <= 1'b0;
      bus.pkt_cnt  <= '0;
      bus.drop_cnt <= '0;
    end else begin
      bus.pop  <= '0;
      bus.push <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            win_q     <= win_d;
            bus.grant <= ONE << win_d;
            bus.busy  <= 1'b1;
            state     <= POP;
          end
        end
        POP: begin
          bus.pop <= ONE << win_q;
          pkt_reg <= bus.D_pop[int'(win_q)*pckg_sz +: pckg_sz];
          state   <= DELIVER;
        end
        DELIVER: begin
          bus.D_push <= pkt_reg;
          if (int'(dest) < drvrs) begin
            bus.push <= ONE << dest;
            if (bus.pkt_cnt != 16'hFFFF)
              bus.pkt_cnt <= bus.pkt_cnt + 16'd1;
          end else if (dest == broadcast) begin
            // every device but the source; empty when drvrs == 1
            bus.push <= ~(ONE << win_q);
            if (bus.pkt_cnt != 16'hFFFF)
              bus.pkt_cnt <= bus.pkt_cnt + 16'd1;
          end else begin
            if (bus.drop_cnt != 16'hFFFF)
              bus.drop_cnt <= bus.drop_cnt + 16'd1;
          end
          ptr       <= win_q;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed self-checking bench for bus_rr_scheduler.
// Drives the slave side of the interface; checks #1 after clock edges.
`timescale 1ns/1ps
module tb_bus_rr_scheduler;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  bus_rr_scheduler_if #(.drvrs(4), .pckg_sz(16)) bif ();

  bus_rr_scheduler #(
    .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_pop"},   32'(bif.pop),      32'h0);
    chk({tag, "_push"},  32'(bif.push),     32'h0);
    chk({tag, "_grant"}, 32'(bif.grant),    32'h0);
    chk({tag, "_busy"},  32'(bif.busy),     32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bif.pndng = '0;
    bif.D_pop = '0;
    #2 reset = 1'b0;

    // 1: reset with random inputs, then idle
    for (int i = 0; i < 3; i++) begin
      bif.pndng = 4'($urandom);
      bif.D_pop = {$urandom, $urandom};
      tick();
      chk_idle_outs("rst");
      chk("rst_dpush", 32'(bif.D_push), 32'h0);
      chk("rst_pcnt", 32'(bif.pkt_cnt), 32'h0);
      chk("rst_dcnt", 32'(bif.drop_cnt), 32'h0);
    end
    bif.pndng = '0;
    bif.D_pop = '0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle_outs("idle");
    end

    // 2: single transfer device 0 -> device 2
    bif.pndng = 4'b0001;
    bif.D_pop[15:0] = 16'h02AA;
    tick();
    chk("s_grant", 32'(bif.grant), 32'h1);
    chk("s_busy", 32'(bif.busy), 32'h1);
    chk("s_pop0", 32'(bif.pop), 32'h0);
    tick();
    chk("s_pop", 32'(bif.pop), 32'h1);
    bif.pndng = '0;
    tick();
    chk("s_push", 32'(bif.push), 32'h4);
    chk("s_dpush", 32'(bif.D_push), 32'h02AA);
    chk("s_pop_off", 32'(bif.pop), 32'h0);
    tick();
    chk("s_pcnt", 32'(bif.pkt_cnt), 32'h1);
    chk_idle_outs("s_end");

    // 3: round robin from a fresh pointer, all pending
    reset = 1'b0;
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++)
      bif.D_pop[16*i +: 16] = {8'((i + 1) % 4), 8'h50 + 8'(i)};
    bif.pndng = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_grant", 32'(bif.grant), 32'(1 << (k % 4)));
      tick();
      chk("rr_pop", 32'(bif.pop), 32'(1 << (k % 4)));
      tick();
      chk("rr_push", 32'(bif.push), 32'(1 << ((k + 1) % 4)));
      chk("rr_dpush", 32'(bif.D_push),
          32'({8'(((k % 4) + 1) % 4), 8'h50 + 8'(k % 4)}));
      if (k == 4) bif.pndng = '0;
    end
    chk("rr_pcnt", 32'(bif.pkt_cnt), 32'd5);

    // 4: broadcast from device 2
    bif.D_pop[47:32] = 16'hFFCC;
    bif.pndng = 4'b0100;
    tick();
    chk("bc_grant", 32'(bif.grant), 32'h4);
    tick();
    chk("bc_pop", 32'(bif.pop), 32'h4);
    bif.pndng = '0;
    tick();
    chk("bc_push", 32'(bif.push), 32'hB);
    chk("bc_dpush", 32'(bif.D_push), 32'hFFCC);
    chk("bc_pcnt", 32'(bif.pkt_cnt), 32'd6);

    // 5: invalid destination from device 1
    bif.D_pop[31:16] = 16'h07EE;
    bif.pndng = 4'b0010;
    tick();
    chk("inv_grant", 32'(bif.grant), 32'h2);
    tick();
    chk("inv_pop", 32'(bif.pop), 32'h2);
    bif.pndng = '0;
    tick();
    chk("inv_push", 32'(bif.push), 32'h0);
    chk("inv_dcnt", 32'(bif.drop_cnt), 32'd1);
    chk("inv_pcnt", 32'(bif.pkt_cnt), 32'd6);

    // 6: reset while device 3's delivery is on the bus
    bif.D_pop[63:48] = 16'h0011;
    bif.pndng = 4'b1000;
    tick();
    chk("mr_grant", 32'(bif.grant), 32'h8);
    tick();
    chk("mr_pop", 32'(bif.pop), 32'h8);
    bif.pndng = '0;
    tick();
    chk("mr_push_pre", 32'(bif.push), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk_idle_outs("mr_async");
    chk("mr_pcnt", 32'(bif.pkt_cnt), 32'h0);
    chk("mr_dcnt", 32'(bif.drop_cnt), 32'h0);
    tick();
    reset = 1'b1;
    bif.pndng = 4'b1001;
    tick();
    chk("mr_grant_after", 32'(bif.grant), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
